multicycle_control_fsm: RTL and testbench

Main control unit of the multicycle processor. It is a Moore state machine plus a combinational ALU decoder. It sequences each instruction through Fetch, Decode, Execute, Memory and Writeback. It drives every datapath select line (IorD, ALUSrcA, ALUSrcB, PCSrc, RegDst, MemtoReg), so it sits directly upstream of the MUX2/MUX4 select inputs, the register enables and memory write.

---
 rtl/multicycle_control_fsm_pkg.sv | 63 ++++++
 rtl/multicycle_control_fsm_alu_decoder.sv | 29 ++
 rtl/multicycle_control_fsm.sv | 132 +++++++++++++
 tb/tb_multicycle_control_fsm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// ALUOp and ALUControl codes, plus the packed control word driven per state.
package multicycle_control_fsm_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned ALUCTL_W = 3;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  // Moore control word decoded from the current state.
  typedef struct packed {
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field to an ALU operation.
module multicycle_control_fsm_alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [ALUOP_W-1:0]  alu_op_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  output logic [ALUCTL_W-1:0] alu_control_c
);

  always_comb begin
    alu_control_c = ALUCTL_ADD;
    case (alu_op_i)
      ALUOP_ADD:   alu_control_c = ALUCTL_ADD;
      ALUOP_SUB:   alu_control_c = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_c = ALUCTL_ADD;
          FN_SUB:  alu_control_c = ALUCTL_SUB;
          FN_AND:  alu_control_c = ALUCTL_AND;
          FN_OR:   alu_control_c = ALUCTL_OR;
          FN_SLT:  alu_control_c = ALUCTL_SLT;
          default: alu_control_c = ALUCTL_ADD;
        endcase
      end
      default:     alu_control_c = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle processor main control: Moore FSM sequencing each instruction,
// with datapath selects decoded from the state register and an ALU decoder.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned OpcodeWidth = OPCODE_W,
  parameter int unsigned FunctWidth  = FUNCT_W,
  parameter int unsigned StateWidth  = STATE_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [OpcodeWidth-1:0] Opcode,
  input  logic [FunctWidth-1:0]  Funct,
  input  logic                   Zero,
  output logic                   IorD,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSrc,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   MemWrite,
  output logic                   RegWrite,
  output logic                   PCEn,
  output logic [2:0]             ALUControl,
  output logic [StateWidth-1:0]  State
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              ctrl;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic; illegal codes 12-15 fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode: every field defaults to zero.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD:  ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB:   ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default:    ctrl = '0;
    endcase
  end

  multicycle_control_fsm_alu_decoder u_alu_decoder (
    .alu_op_i      (ctrl.alu_op),
    .funct_i       (FUNCT_W'(Funct)),
    .alu_control_c (ALUControl)
  );

  assign IorD     = ctrl.iord;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign PCSrc    = ctrl.pc_src;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign IRWrite  = ctrl.ir_write;
  assign MemWrite = ctrl.mem_write;
  assign RegWrite = ctrl.reg_write;
  // Branch resolves in the same cycle from the live Zero flag.
  assign PCEn     = ctrl.pc_write | (ctrl.branch & Zero);
  assign State    = StateWidth'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// through its state sequence and checks the decoded controls.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCEn(PCEn),
    .ALUControl(ALUControl), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0;
    // Reset held across clock edges
    step(); step();
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd1);
    chk("rst_pcen", 32'(PCEn), 32'd1);
    chk("rst_alusrcb", 32'(ALUSrcB), 32'd1);
    chk("rst_enables", 32'({MemWrite, RegWrite, IorD, ALUSrcA, PCSrc, RegDst, MemtoReg}), 32'd0);
    RST = 1'b1;

    // LW: 0,1,2,3,4,0
    Opcode = OP_LW;
    step(); chk("lw_s1", 32'(State), 32'd1);
    chk("lw_s1_alusrcb", 32'(ALUSrcB), 32'd3);
    chk("lw_s1_en", 32'({RegWrite, MemWrite, PCEn, IRWrite}), 32'd0);
    step(); chk("lw_s2", 32'(State), 32'd2);
    chk("lw_s2_src", 32'({ALUSrcA, ALUSrcB}), 32'b110);
    step(); chk("lw_s3", 32'(State), 32'd3);
    chk("lw_s3_iord", 32'(IorD), 32'd1);
    chk("lw_s3_rw", 32'({RegWrite, MemtoReg}), 32'd0);
    step(); chk("lw_s4", 32'(State), 32'd4);
    chk("lw_s4_rw", 32'({RegWrite, MemtoReg}), 32'b11);
    step(); chk("lw_back", 32'(State), 32'd0);

    // R-type: 0,1,6,7,0 with funct sweep in EXECUTER
    Opcode = OP_RTYPE; Funct = 6'b100010;
    step(); chk("r_s1", 32'(State), 32'd1);
    step(); chk("r_s6", 32'(State), 32'd6);
    chk("r_sub", 32'(ALUControl), 32'b110);
    Funct = 6'b101010; #1 chk("r_slt", 32'(ALUControl), 32'b111);
    Funct = 6'b111111; #1 chk("r_other", 32'(ALUControl), 32'b010);
    Funct = 6'b100100; #1 chk("r_and", 32'(ALUControl), 32'b000);
    Funct = 6'b100101; #1 chk("r_or", 32'(ALUControl), 32'b001);
    step(); chk("r_s7", 32'(State), 32'd7);
    chk("r_s7_wb", 32'({RegDst, RegWrite, MemtoReg}), 32'b110);
    step(); chk("r_back", 32'(State), 32'd0);

    // BEQ: 0,1,8,0 with Zero toggled inside BRANCH
    Opcode = OP_BEQ; Zero = 1'b1;
    step(); chk("beq_s1", 32'(State), 32'd1);
    chk("beq_s1_alu", 32'(ALUControl), 32'b010);
    step(); chk("beq_s8", 32'(State), 32'd8);
    chk("beq_taken_pcen", 32'(PCEn), 32'd1);
    chk("beq_pcsrc", 32'(PCSrc), 32'b01);
    chk("beq_alu", 32'(ALUControl), 32'b110);
    Zero = 1'b0; #1 chk("beq_nt_pcen", 32'(PCEn), 32'd0);
    step(); chk("beq_back", 32'(State), 32'd0);

    // SW: 0,1,2,5,0
    Opcode = OP_SW;
    step(); chk("sw_s1", 32'(State), 32'd1);
    step(); chk("sw_s2", 32'(State), 32'd2);
    chk("sw_s2_mw", 32'(MemWrite), 32'd0);
    step(); chk("sw_s5", 32'(State), 32'd5);
    chk("sw_s5_mw", 32'({MemWrite, IorD}), 32'b11);
    step(); chk("sw_back", 32'(State), 32'd0);

    // J: 0,1,11,0
    Opcode = OP_J;
    step(); step(); chk("j_s11", 32'(State), 32'd11);
    chk("j_ctl", 32'({PCSrc, PCEn}), 32'b101);
    step(); chk("j_back", 32'(State), 32'd0);

    // ADDI: 0,1,9,10,0
    Opcode = OP_ADDI;
    step(); step(); chk("addi_s9", 32'(State), 32'd9);
    chk("addi_s9_src", 32'({ALUSrcA, ALUSrcB, RegWrite}), 32'b1100);
    step(); chk("addi_s10", 32'(State), 32'd10);
    chk("addi_s10_wb", 32'({RegWrite, RegDst, MemtoReg}), 32'b100);
    step(); chk("addi_back", 32'(State), 32'd0);

    // Illegal opcode: 0,1,0 with no enables in DECODE
    Opcode = 6'b111111;
    step(); chk("ill_s1", 32'(State), 32'd1);
    chk("ill_en", 32'({RegWrite, MemWrite, PCEn}), 32'd0);
    step(); chk("ill_back", 32'(State), 32'd0);

    // Asynchronous reset in the middle of MEMWRITE
    Opcode = OP_SW;
    step(); step(); step(); chk("mid_s5", 32'(State), 32'd5);
    #2 RST = 1'b0;
    #1 chk("mid_rst_state", 32'(State), 32'd0);
    chk("mid_rst_mw", 32'(MemWrite), 32'd0);
    @(negedge CLK); RST = 1'b1;

    // Illegal state code recovers to FETCH on the next edge
    @(negedge CLK);
    force dut.state_q = 4'd12;
    #1 chk("force_state", 32'(State), 32'd12);
    chk("force_next", 32'(dut.state_d), 32'd0);
    chk("force_outs", 32'({IRWrite, PCEn, RegWrite, MemWrite}), 32'd0);
    release dut.state_q;
    step(); chk("force_recover", 32'(State), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
